// File: rtl/risc_pkg.sv
// Shared opcode bit positions, memory-stage FSM states and error codes.
package risc_pkg;

  localparam int OPC_W     = 24;
  localparam int OPC_ADD   = 0;
  localparam int OPC_SUB   = 1;
  localparam int OPC_STORE = 2;
  localparam int OPC_LOAD  = 3;
  localparam int OPC_AND   = 4;
  localparam int OPC_OR    = 5;
  localparam int OPC_XOR   = 6;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MEM  = 1'b1
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  function automatic logic is_mem_op(input logic [OPC_W-1:0] opc);
    return opc[OPC_STORE] | opc[OPC_LOAD];
  endfunction

endpackage

// File: rtl/mem_stage.sv
// Memory stage: ALU ops pass through in 1 cycle; loads/stores run one data-memory request (>=2 cycles).
// Accepts only when idle and the output slot is free or draining; the output entry holds until wb_ready.
module mem_stage
  import risc_pkg::*;
#(
  parameter int AW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic [OPC_W-1:0]    ex_opc,
  input  logic [31:0]         ex_alu,
  input  logic [31:0]         ex_sdata,
  input  logic [4:0]          ex_rd,
  output logic                dm_req,
  output logic                dm_we,
  output logic [AW-1:0]       dm_addr,
  output logic [31:0]         dm_wdata,
  input  logic [31:0]         dm_rdata,
  input  logic                dm_ack,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic                wb_we,
  output logic [4:0]          wb_rd,
  output logic [31:0]         wb_data,
  output logic [1:0]          err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // Expiry is decided on the last allowed cycle so dm_req is up for exactly TIMEOUT cycles.
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  state_e        state_q,    state_d;
  logic          dm_req_q,   dm_req_d;
  logic          dm_we_q,    dm_we_d;
  logic [AW-1:0] dm_addr_q,  dm_addr_d;
  logic [31:0]   dm_wdata_q, dm_wdata_d;
  logic          wb_valid_q, wb_valid_d;
  logic          wb_we_q,    wb_we_d;
  logic [4:0]    wb_rd_q,    wb_rd_d;
  logic [31:0]   wb_data_q,  wb_data_d;
  logic [1:0]    err_q,      err_d;
  logic [CW-1:0] tmo_cnt_q,  tmo_cnt_d;

  logic ex_fire;
  logic op_mem;
  logic op_store;

  assign ex_ready = (state_q == IDLE) && (!wb_valid_q || wb_ready);
  assign ex_fire  = ex_valid && ex_ready;
  assign op_mem   = is_mem_op(ex_opc);
  assign op_store = ex_opc[OPC_STORE];

  always_comb begin
    state_d    = state_q;
    dm_req_d   = dm_req_q;
    dm_we_d    = dm_we_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    wb_valid_d = wb_valid_q;
    wb_we_d    = wb_we_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    err_d      = ERR_NONE;
    tmo_cnt_d  = tmo_cnt_q;

    if (wb_valid_q && wb_ready) begin
      wb_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (ex_fire && (ex_opc != '0)) begin
          wb_rd_d = ex_rd;
          if (!op_mem) begin
            wb_valid_d = 1'b1;
            wb_data_d  = ex_alu;
            wb_we_d    = (ex_rd != 5'd0);
          end else if (ex_alu[1:0] != 2'b00) begin
            wb_valid_d = 1'b1;
            wb_we_d    = 1'b0;
            err_d      = ERR_MISALIGN;
          end else begin
            state_d    = MEM;
            dm_req_d   = 1'b1;
            dm_we_d    = op_store;
            dm_addr_d  = ex_alu[AW+1:2];
            dm_wdata_d = op_store ? ex_sdata : 32'd0;
            tmo_cnt_d  = '0;
          end
        end
      end

      MEM: begin
        // The output slot is guaranteed empty here, so completion never waits on wb_ready.
        if (dm_ack) begin
          state_d    = IDLE;
          dm_req_d   = 1'b0;
          wb_valid_d = 1'b1;
          if (dm_we_q) begin
            wb_we_d = 1'b0;
          end else begin
            wb_data_d = dm_rdata;
            wb_we_d   = (wb_rd_q != 5'd0);
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d    = IDLE;
          dm_req_d   = 1'b0;
          wb_valid_d = 1'b1;
          wb_we_d    = 1'b0;
          err_d      = ERR_TIMEOUT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CW'(1);
        end
      end

      default: begin
        state_d  = IDLE;
        dm_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      err_q      <= ERR_NONE;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      dm_req_q   <= dm_req_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      err_q      <= err_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign dm_req   = dm_req_q;
  assign dm_we    = dm_we_q;
  assign dm_addr  = dm_addr_q;
  assign dm_wdata = dm_wdata_q;
  assign wb_valid = wb_valid_q;
  assign wb_we    = wb_we_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: single-op vector table plus hand sequences for memory corner cases.
module tb_mem_stage;

  localparam logic [23:0] OP_ADD   = 24'h000001;
  localparam logic [23:0] OP_SUB   = 24'h000002;
  localparam logic [23:0] OP_STORE = 24'h000004;
  localparam logic [23:0] OP_LOAD  = 24'h000008;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [23:0] ex_opc;
  logic [31:0] ex_alu;
  logic [31:0] ex_sdata;
  logic [4:0]  ex_rd;
  logic        dm_req;
  logic        dm_we;
  logic [15:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  err;

  int checks = 0;
  int errors = 0;

  mem_stage #(.AW(16), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opc(ex_opc), .ex_alu(ex_alu),
    .ex_sdata(ex_sdata), .ex_rd(ex_rd),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] opc;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        e_vld;
    logic        e_we;
    logic        chk_data;
    logic [31:0] e_data;
    logic [1:0]  e_err;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(input logic [23:0] opc, input logic [31:0] alu, input logic [4:0] rd,
                              input logic e_vld, input logic e_we, input logic chk_data,
                              input logic [31:0] e_data, input logic [1:0] e_err);
    vec_t v;
    v.opc = opc; v.alu = alu; v.rd = rd; v.e_vld = e_vld; v.e_we = e_we;
    v.chk_data = chk_data; v.e_data = e_data; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [23:0] opc, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [4:0] rd);
    ex_valid = 1'b1; ex_opc = opc; ex_alu = alu; ex_sdata = sd; ex_rd = rd;
  endtask

  initial begin
    int n;
    rst = 1'b1; ex_valid = 1'b0; ex_opc = '0; ex_alu = '0; ex_sdata = '0; ex_rd = '0;
    dm_rdata = '0; dm_ack = 1'b0; wb_ready = 1'b1;

    vecs[0] = mk(OP_ADD,   32'h0000_0005, 5'd3,  1'b1, 1'b1, 1'b1, 32'h0000_0005, 2'b00);
    vecs[1] = mk(OP_SUB,   32'hFFFF_FFFF, 5'd31, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 2'b00);
    vecs[2] = mk(OP_ADD,   32'h0000_0123, 5'd0,  1'b1, 1'b0, 1'b1, 32'h0000_0123, 2'b00);
    vecs[3] = mk(24'h0,    32'h0000_0055, 5'd9,  1'b0, 1'b0, 1'b0, 32'h0,         2'b00);
    vecs[4] = mk(OP_LOAD,  32'h0000_0041, 5'd6,  1'b1, 1'b0, 1'b0, 32'h0,         2'b01);
    vecs[5] = mk(OP_STORE, 32'h0000_0006, 5'd0,  1'b1, 1'b0, 1'b0, 32'h0,         2'b01);
    vecs[6] = mk(OP_LOAD,  32'h0000_0042, 5'd0,  1'b1, 1'b0, 1'b0, 32'h0,         2'b01);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_dm_req",   dm_req,   0);
    check("rst_err",      err,      0);
    check("rst_wb_data",  wb_data,  0);
    check("rst_dm_addr",  dm_addr,  0);
    check("rst_ex_ready", ex_ready, 1);
    rst = 1'b0;

    // Single-op vector table
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(vecs[i].opc, vecs[i].alu, 32'hA5A5_A5A5, vecs[i].rd);
      check($sformatf("vec%0d_ex_ready", i), ex_ready, 1);
      @(negedge clk);
      ex_valid = 1'b0;
      check($sformatf("vec%0d_wb_valid", i), wb_valid, vecs[i].e_vld);
      check($sformatf("vec%0d_err", i), err, vecs[i].e_err);
      check($sformatf("vec%0d_dm_req", i), dm_req, 0);
      if (vecs[i].e_vld) begin
        check($sformatf("vec%0d_wb_we", i), wb_we, vecs[i].e_we);
        check($sformatf("vec%0d_wb_rd", i), wb_rd, vecs[i].rd);
      end
      if (vecs[i].chk_data) check($sformatf("vec%0d_wb_data", i), wb_data, vecs[i].e_data);
    end
    @(negedge clk);

    // Back-to-back ALU results
    drive(OP_ADD, 32'h5, 32'h0, 5'd3);
    @(negedge clk);
    check("b2b_1_valid", wb_valid, 1);
    check("b2b_1_data",  wb_data,  32'h5);
    check("b2b_1_we",    wb_we,    1);
    check("b2b_1_ready", ex_ready, 1);
    drive(OP_ADD, 32'hA, 32'h0, 5'd3);
    @(negedge clk);
    ex_valid = 1'b0;
    check("b2b_2_valid", wb_valid, 1);
    check("b2b_2_data",  wb_data,  32'hA);
    check("b2b_2_ready", ex_ready, 1);
    @(negedge clk);
    check("b2b_drain", wb_valid, 0);

    // Load with ack in the first request cycle
    drive(OP_LOAD, 32'h40, 32'hFFFF_FFFF, 5'd7);
    @(negedge clk);
    ex_valid = 1'b0;
    check("ld_req",      dm_req,   1);
    check("ld_addr",     dm_addr,  32'h10);
    check("ld_we",       dm_we,    0);
    check("ld_wdata",    dm_wdata, 0);
    check("ld_ex_ready", ex_ready, 0);
    check("ld_wb_valid", wb_valid, 0);
    dm_ack = 1'b1; dm_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    dm_ack = 1'b0;
    check("ld_done_valid", wb_valid, 1);
    check("ld_done_data",  wb_data,  32'hDEAD_BEEF);
    check("ld_done_we",    wb_we,    1);
    check("ld_done_rd",    wb_rd,    7);
    check("ld_done_err",   err,      0);
    check("ld_done_req",   dm_req,   0);
    @(negedge clk);

    // Store acked on its third request cycle
    drive(OP_STORE, 32'h8, 32'h1234, 5'd0);
    @(negedge clk);
    ex_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("st_c%0d_req", c),   dm_req,   1);
      check($sformatf("st_c%0d_we", c),    dm_we,    1);
      check($sformatf("st_c%0d_wdata", c), dm_wdata, 32'h1234);
      check($sformatf("st_c%0d_addr", c),  dm_addr,  32'h2);
      check($sformatf("st_c%0d_ready", c), ex_ready, 0);
      check($sformatf("st_c%0d_wbv", c),   wb_valid, 0);
      if (c == 3) dm_ack = 1'b1;
      @(negedge clk);
    end
    dm_ack = 1'b0;
    check("st_done_valid", wb_valid, 1);
    check("st_done_we",    wb_we,    0);
    check("st_done_err",   err,      0);
    check("st_done_data",  wb_data,  32'hDEAD_BEEF);
    check("st_done_req",   dm_req,   0);
    @(negedge clk);

    // Misaligned error pulses only on the first valid cycle while stalled
    wb_ready = 1'b0;
    drive(OP_LOAD, 32'h43, 32'h0, 5'd5);
    @(negedge clk);
    ex_valid = 1'b0;
    check("mis_stall_valid", wb_valid, 1);
    check("mis_stall_err1",  err,      1);
    check("mis_stall_ready", ex_ready, 0);
    check("mis_stall_req",   dm_req,   0);
    @(negedge clk);
    check("mis_stall_err2",  err,      0);
    check("mis_stall_hold",  wb_valid, 1);
    wb_ready = 1'b1;
    @(negedge clk);
    check("mis_drain", wb_valid, 0);

    // Load that never gets acked
    drive(OP_LOAD, 32'h20, 32'h0, 5'd9);
    @(negedge clk);
    ex_valid = 1'b0;
    n = 0;
    while (dm_req === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("tmo_req_cycles", n,        15);
    check("tmo_valid",      wb_valid, 1);
    check("tmo_err",        err,      2);
    check("tmo_we",         wb_we,    0);
    @(negedge clk);

    // Ack on the expiry cycle completes normally
    drive(OP_LOAD, 32'h24, 32'h0, 5'd8);
    @(negedge clk);
    ex_valid = 1'b0;
    repeat (14) @(negedge clk);
    check("exp_ack_req", dm_req, 1);
    dm_ack = 1'b1; dm_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    dm_ack = 1'b0;
    check("exp_ack_valid", wb_valid, 1);
    check("exp_ack_err",   err,      0);
    check("exp_ack_data",  wb_data,  32'hCAFE_F00D);
    check("exp_ack_we",    wb_we,    1);
    @(negedge clk);

    // Output stall then release with next entry waiting
    wb_ready = 1'b0;
    drive(OP_ADD, 32'h77, 32'h0, 5'd4);
    @(negedge clk);
    check("stall_data1",  wb_data,  32'h77);
    check("stall_valid1", wb_valid, 1);
    check("stall_ready1", ex_ready, 0);
    drive(OP_ADD, 32'h88, 32'h0, 5'd4);
    @(negedge clk);
    check("stall_data2",  wb_data,  32'h77);
    check("stall_ready2", ex_ready, 0);
    wb_ready = 1'b1;
    #1;
    check("release_ready", ex_ready, 1);
    @(negedge clk);
    ex_valid = 1'b0;
    check("release_valid", wb_valid, 1);
    check("release_data",  wb_data,  32'h88);
    @(negedge clk);

    // Reset during a memory request, then a late ack
    drive(OP_LOAD, 32'h80, 32'h0, 5'd1);
    @(negedge clk);
    ex_valid = 1'b0;
    check("rmem_req1", dm_req, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rmem_req_drop", dm_req,   0);
    check("rmem_wbv",      wb_valid, 0);
    dm_ack = 1'b1; dm_rdata = 32'hBAD0_BAD0;
    drive(OP_ADD, 32'h99, 32'h0, 5'd2);
    @(negedge clk);
    ex_valid = 1'b0; dm_ack = 1'b0;
    check("rmem_add_valid", wb_valid, 1);
    check("rmem_add_data",  wb_data,  32'h99);
    check("rmem_add_err",   err,      0);
    check("rmem_add_req",   dm_req,   0);
    check("rmem_add_rd",    wb_rd,    2);
    @(negedge clk);
    check("rmem_idle_req", dm_req,   0);
    check("rmem_idle_wbv", wb_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the ALU; consumes the ALU result (DOut) plus the 24-bit one-hot opcode.
- Load/store: drives a single-outstanding data-memory request/acknowledge handshake.
- All other ops: registers the ALU result straight through.
- Output is a one-entry pipeline register with valid/ready handshakes on both sides, feeding writeback.

Parameters:
- AW, 16, word-address width driven to data memory; byte address bits [AW+1:2] used.
- TIMEOUT, 15, max cycles dm_req may wait for dm_ack before abort (1..255).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  upstream entry valid
- ex_ready  out  1  stage can accept this cycle
- ex_opc  in  24  one-hot opcode (bit2 store, bit3 load, others non-memory)
- ex_alu  in  32  ALU DOut: byte address for load/store, result otherwise
- ex_sdata  in  32  store data (rs1 value)
- ex_rd  in  5  destination register
- dm_req  out  1  memory request
- dm_we  out  1  1 = write
- dm_addr  out  AW  word address
- dm_wdata  out  32  write data
- dm_rdata  in  32  read data, valid with dm_ack
- dm_ack  in  1  request completed this cycle
- wb_valid  out  1  output entry valid
- wb_ready  in  1  writeback accepts
- wb_we  out  1  register write enable
- wb_rd  out  5  destination register
- wb_data  out  32  writeback data
- err  out  2  one-cycle error pulse with wb_valid: 00 none, 01 misaligned, 10 timeout

Behaviour:
- Reset: state IDLE; dm_req, dm_we, wb_valid, wb_we, err = 0; dm_addr, dm_wdata, wb_rd, wb_data = 0; timeout counter = 0.
- Handshake:
  - ex_ready = (state==IDLE) && (!wb_valid || wb_ready).
  - Transfer on ex_valid && ex_ready.
  - wb entry holds stable until wb_valid && wb_ready.
- Transfer with ex_opc==0 (bubble): consumed; produces no output.
- Non-memory op:
  - Next cycle wb_valid=1, wb_data=ex_alu, wb_rd=ex_rd, wb_we=(ex_rd!=0), err=00.
  - Latency 1; full throughput.
- Load/store with ex_alu[1:0]!=0:
  - No memory access.
  - Next cycle wb_valid=1, wb_we=0, err=01.
- Aligned load/store:
  - Next cycle: state MEM, dm_req=1, dm_we=store, dm_addr=ex_alu[AW+1:2], dm_wdata=ex_sdata (store), 0 (load).
- State MEM:
  - dm_req/dm_we/dm_addr/dm_wdata held stable until completion.
  - dm_ack may be high in the first dm_req cycle.
  - On dm_ack, next cycle: dm_req=0, state IDLE, wb_valid=1, err=00.
  - Load completion: wb_data=dm_rdata, wb_we=(rd!=0).
  - Store completion: wb_we=0, wb_data unchanged.
  - Minimum load latency: 2 cycles from transfer to wb_valid.
- Output slot is always empty while in MEM (guaranteed by the ex_ready rule), so completion never blocks.
- Timeout:
  - Counter clears on MEM entry and increments each MEM cycle without dm_ack.
  - If the counter reaches TIMEOUT with no ack, next cycle: dm_req=0, state IDLE, wb_valid=1, wb_we=0, err=10.
  - dm_ack arriving in the same cycle as expiry wins (normal completion).
- err is asserted only on the first cycle wb_valid rises for that entry; 00 while stalled.
- dm_ack outside MEM is ignored.
- rst in MEM: dm_req drops at that edge; the in-flight entry is discarded. Memory must tolerate the abandoned request.

Decomposition:
- Shared package risc_pkg:
  - opcode bit indices (OPC_STORE=2, OPC_LOAD=3, ...);
  - state enum {IDLE, MEM};
  - err codes ERR_NONE/ERR_MISALIGN/ERR_TIMEOUT.
- No sub-module needed; the timeout counter stays inline (width $clog2(TIMEOUT+1)).

Test Plan:
- Back-to-back add results 0x5, 0xA, rd=3, wb_ready=1 -> wb_valid every cycle, wb_data 0x5 then 0xA, wb_we=1, ex_ready stays 1.
- Load addr 0x40, memory acks in first req cycle with 0xDEADBEEF, rd=7 -> dm_addr=0x10, dm_we=0; wb_data=0xDEADBEEF, wb_we=1, 2 cycles after transfer.
- Store addr 0x8, data 0x1234, ack after 3 cycles -> dm_we=1, dm_wdata=0x1234 held stable; ex_ready=0 throughout; wb_valid with wb_we=0.
- Load addr 0x41 -> no dm_req; wb_valid, wb_we=0, err=01. Load with no ack, TIMEOUT=15 -> dm_req high 15 cycles, then err=10.
- wb_ready=0 with add result held -> wb_data stable, ex_ready=0. Release -> next entry accepted the same cycle.
- rst asserted in MEM cycle 2 -> dm_req=0, wb_valid=0 next edge. Subsequent add proceeds normally. Late dm_ack is ignored.
